// File: rtl/rx_packet_framer.sv
// Receive-side packet framer: scans the channel FIFOs round-robin and emits one
// fixed 256-word packet (header, payload, zero pad) as an unbroken USB FIFO burst.
module rx_packet_framer #(
  parameter int NUM_CHAN  = 2,
  parameter int PKT_WORDS = 256,
  parameter int HDR_WORDS = 4
) (
  input  logic                rxclk,
  input  logic                reset_n,
  input  logic [31:0]         adctime,
  input  logic                have_space,
  input  logic [9:0]          chan_usedw,
  input  logic [NUM_CHAN:0]   chan_empty,
  input  logic [15:0]         chan_fifodata,
  input  logic                overrun,
  input  logic [1:0]          underrun,
  output logic [3:0]          rd_select,
  output logic                chan_rdreq,
  output logic                WR,
  output logic [15:0]         fifodata,
  output logic                busy
);

  localparam int               MAX_PAY       = PKT_WORDS - HDR_WORDS;
  localparam int               LEN_W         = $clog2(MAX_PAY + 1);
  localparam logic [9:0]       MAX_PAY_USEDW = 10'(MAX_PAY);
  localparam logic [LEN_W-1:0] MAX_PAY_LEN   = LEN_W'(MAX_PAY);
  localparam logic [LEN_W-1:0] LAST_WORD     = LEN_W'(MAX_PAY - 1);
  localparam logic [3:0]       CMD_SEL       = 4'(NUM_CHAN);

  localparam logic [2:0] S_SCAN = 3'd0;
  localparam logic [2:0] S_HDR0 = 3'd1;
  localparam logic [2:0] S_HDR1 = 3'd2;
  localparam logic [2:0] S_HDR2 = 3'd3;
  localparam logic [2:0] S_HDR3 = 3'd4;
  localparam logic [2:0] S_PAY  = 3'd5;
  localparam logic [2:0] S_PAD  = 3'd6;

  logic [2:0]       state;
  logic [LEN_W-1:0] pay_len;
  logic [LEN_W-1:0] word_cnt;
  logic [31:0]      ts;
  logic [15:0]      hdr_data;
  logic             wr_r;

  logic             is_cmd;
  logic             empty_sel;
  logic             eligible;
  logic [LEN_W-1:0] len_next;
  logic [8:0]       byte_cnt;
  logic [3:0]       sel_next;
  logic [4:0]       chan_id;

  // Payload length is capped at one frame; an empty-looking but non-empty
  // command FIFO has wrapped its usedw counter and is therefore full.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [9:0] usedw,
                                                 input logic       cmd);
    if (cmd && usedw == 10'd0)
      return MAX_PAY_LEN;
    else if (usedw >= MAX_PAY_USEDW)
      return MAX_PAY_LEN;
    else
      return usedw[LEN_W-1:0];
  endfunction

  always_comb begin
    empty_sel = 1'b1;
    for (int i = 0; i <= NUM_CHAN; i++)
      if (rd_select == 4'(i)) empty_sel = chan_empty[i];
  end

  assign is_cmd   = (rd_select == CMD_SEL);
  assign eligible = is_cmd ? !empty_sel
                           : (!empty_sel && chan_usedw >= MAX_PAY_USEDW);
  assign len_next = clamp_len(chan_usedw, is_cmd);
  assign byte_cnt = 9'({len_next, 1'b0});
  assign sel_next = is_cmd ? 4'd0 : rd_select + 4'd1;
  assign chan_id  = is_cmd ? 5'h1F : {1'b0, rd_select};

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_SCAN;
      rd_select <= 4'd0;
      pay_len   <= '0;
      word_cnt  <= '0;
      ts        <= 32'd0;
      hdr_data  <= 16'd0;
      wr_r      <= 1'b0;
    end else begin
      case (state)
        S_SCAN: begin
          if (eligible && have_space) begin
            state    <= S_HDR0;
            pay_len  <= len_next;
            ts       <= adctime;
            wr_r     <= 1'b1;
            hdr_data <= {3'b000, overrun, |underrun, 2'b00, byte_cnt};
          end else begin
            rd_select <= sel_next;
          end
        end
        S_HDR0: begin
          state    <= S_HDR1;
          hdr_data <= {11'd0, chan_id};
        end
        S_HDR1: begin
          state    <= S_HDR2;
          hdr_data <= ts[15:0];
        end
        S_HDR2: begin
          state    <= S_HDR3;
          hdr_data <= ts[31:16];
        end
        // Clearing hdr_data here makes the pad words zero for free.
        S_HDR3: begin
          state    <= S_PAY;
          hdr_data <= 16'd0;
          word_cnt <= '0;
        end
        S_PAY: begin
          word_cnt <= word_cnt + LEN_W'(1);
          if (word_cnt == pay_len - LEN_W'(1)) begin
            if (pay_len == MAX_PAY_LEN) begin
              state     <= S_SCAN;
              wr_r      <= 1'b0;
              rd_select <= sel_next;
              word_cnt  <= '0;
            end else begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          word_cnt <= word_cnt + LEN_W'(1);
          if (word_cnt == LAST_WORD) begin
            state     <= S_SCAN;
            wr_r      <= 1'b0;
            rd_select <= sel_next;
            word_cnt  <= '0;
          end
        end
        default: begin
          state <= S_SCAN;
          wr_r  <= 1'b0;
        end
      endcase
    end
  end

  // Reads run one cycle ahead of the payload writes; FIFO q goes straight out.
  assign chan_rdreq = (state == S_HDR3) ||
                      (state == S_PAY && (word_cnt + LEN_W'(1)) < pay_len);
  assign fifodata   = (state == S_PAY) ? chan_fifodata : hdr_data;
  assign WR         = wr_r;
  assign busy       = (state != S_SCAN);

endmodule

// File: tb/tb_rx_packet_framer.sv
// Directed bench for rx_packet_framer with a small channel-FIFO model whose
// words encode {channel, sequence} so payload order is checkable.
module tb_rx_packet_framer;

  localparam int NUM_CHAN  = 2;
  localparam int PKT_WORDS = 256;
  localparam int MAX_PAY   = 252;

  logic                rxclk;
  logic                reset_n;
  logic [31:0]         adctime;
  logic                have_space;
  logic [9:0]          chan_usedw;
  logic [NUM_CHAN:0]   chan_empty;
  logic [15:0]         chan_fifodata;
  logic                overrun;
  logic [1:0]          underrun;
  logic [3:0]          rd_select;
  logic                chan_rdreq;
  logic                WR;
  logic [15:0]         fifodata;
  logic                busy;

  int total = 0;
  int bad   = 0;

  int load  [NUM_CHAN+1] = '{0, 0, 0};
  int taken [NUM_CHAN+1] = '{0, 0, 0};

  rx_packet_framer #(
    .NUM_CHAN (NUM_CHAN),
    .PKT_WORDS(PKT_WORDS),
    .HDR_WORDS(4)
  ) dut (
    .rxclk        (rxclk),
    .reset_n      (reset_n),
    .adctime      (adctime),
    .have_space   (have_space),
    .chan_usedw   (chan_usedw),
    .chan_empty   (chan_empty),
    .chan_fifodata(chan_fifodata),
    .overrun      (overrun),
    .underrun     (underrun),
    .rd_select    (rd_select),
    .chan_rdreq   (chan_rdreq),
    .WR           (WR),
    .fifodata     (fifodata),
    .busy         (busy)
  );

  initial rxclk = 1'b0;
  always #5 rxclk = ~rxclk;

  // Normal-mode FIFO model: q updates on the edge that sees rdreq.
  always @(posedge rxclk) begin
    int s;
    s = int'(rd_select);
    if (chan_rdreq && s <= NUM_CHAN) begin
      chan_fifodata <= {rd_select, 12'(taken[s])};
      taken[s]      <= taken[s] + 1;
    end
  end

  always_comb begin
    int s;
    int av;
    chan_empty = '1;
    chan_usedw = 10'd0;
    s  = int'(rd_select);
    av = 0;
    for (int c = 0; c <= NUM_CHAN; c++)
      chan_empty[c] = (load[c] - taken[c]) <= 0;
    if (s <= NUM_CHAN) begin
      av = load[s] - taken[s];
      chan_usedw = (av > 1023) ? 10'd1023 : 10'(av);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_avail(input int c, input int n);
    load[c] = taken[c] + n;
  endtask

  task automatic verify_pkt(input string tag, input logic [15:0] h0, input logic [15:0] h1,
                            input logic [31:0] stamp, input logic [15:0] base,
                            input int n, input bit toggle);
    int t;
    int wr_cnt;
    int busy_cnt;
    int rd_cnt;
    logic [15:0] pkt [PKT_WORDS];
    t = 0; wr_cnt = 0; busy_cnt = 0; rd_cnt = 0;
    while (WR !== 1'b1 && t < 64) begin
      @(negedge rxclk);
      t++;
    end
    check({tag, "_start"}, 32'(WR), 32'd1);
    for (int i = 0; i < PKT_WORDS; i++) begin
      pkt[i]    = fifodata;
      wr_cnt   += int'(WR);
      busy_cnt += int'(busy);
      rd_cnt   += int'(chan_rdreq);
      if (toggle && i > 0) begin
        overrun    = ~overrun;
        have_space = ~have_space;
      end
      @(negedge rxclk);
    end
    check({tag, "_wrcnt"}, 32'(wr_cnt), 32'd256);
    check({tag, "_busycnt"}, 32'(busy_cnt), 32'd256);
    check({tag, "_wr_after"}, 32'(WR), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_rdreqs"}, 32'(rd_cnt), 32'(n));
    check({tag, "_hdr0"}, 32'(pkt[0]), 32'(h0));
    check({tag, "_hdr1"}, 32'(pkt[1]), 32'(h1));
    check({tag, "_hdr2"}, 32'(pkt[2]), 32'(stamp[15:0]));
    check({tag, "_hdr3"}, 32'(pkt[3]), 32'(stamp[31:16]));
    for (int i = 0; i < n; i++)
      check({tag, "_pay"}, 32'(pkt[4+i]), 32'(base + 16'(i)));
    for (int i = n; i < MAX_PAY; i++)
      check({tag, "_pad"}, 32'(pkt[4+i]), 32'd0);
  endtask

  initial begin
    int t;
    reset_n    = 1'b0;
    have_space = 1'b1;
    adctime    = 32'h1234_5678;
    overrun    = 1'b0;
    underrun   = 2'b00;
    set_avail(0, 300);
    repeat (3) @(negedge rxclk);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_rdreq", 32'(chan_rdreq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel", 32'(rd_select), 32'd0);
    check("rst_data", 32'(fifodata), 32'd0);
    reset_n = 1'b1;

    // ch0 full frame: 504 bytes = 0x1F8 in the count field
    verify_pkt("t1", 16'h01F8, 16'h0000, 32'h1234_5678, 16'h0000, 252, 1'b0);
    check("t1_sel", 32'(rd_select), 32'd1);

    // command channel, 10 words then 242 pad words
    adctime = 32'hCAFE_0001;
    set_avail(2, 10);
    verify_pkt("t2", 16'h0014, 16'h001F, 32'hCAFE_0001, 16'h2000, 10, 1'b0);
    check("t2_sel", 32'(rd_select), 32'd0);

    // both data channels continuously eligible: alternate 0,1,0
    adctime = 32'h0BAD_F00D;
    set_avail(0, 600);
    set_avail(1, 600);
    verify_pkt("t3a", 16'h01F8, 16'h0000, 32'h0BAD_F00D, 16'h00FC, 252, 1'b0);
    verify_pkt("t3b", 16'h01F8, 16'h0001, 32'h0BAD_F00D, 16'h1000, 252, 1'b0);
    verify_pkt("t3c", 16'h01F8, 16'h0000, 32'h0BAD_F00D, 16'h01F8, 252, 1'b0);

    // no space: scanner keeps rotating, nothing written
    have_space = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t4_sel", 32'(rd_select), 32'((1 + i) % 3));
      check("t4_wr", 32'(WR), 32'd0);
      @(negedge rxclk);
    end
    have_space = 1'b1;
    @(negedge rxclk);
    check("t4_latency", 32'(WR), 32'd1);
    verify_pkt("t4", 16'h01F8, 16'h0001, 32'h0BAD_F00D, 16'h10FC, 252, 1'b0);

    // status bits latched at acceptance; overrun toggles mid-packet
    set_avail(0, 300);
    overrun  = 1'b1;
    underrun = 2'b10;
    adctime  = 32'h0001_0002;
    verify_pkt("t5", 16'h19F8, 16'h0000, 32'h0001_0002, 16'h02F4, 252, 1'b1);
    overrun    = 1'b0;
    underrun   = 2'b00;
    have_space = 1'b1;

    // async reset in the middle of the payload
    set_avail(1, 300);
    adctime = 32'h5555_6666;
    t = 0;
    while (WR !== 1'b1 && t < 64) begin
      @(negedge rxclk);
      t++;
    end
    repeat (104) @(negedge rxclk);
    check("t6_pre_wr", 32'(WR), 32'd1);
    check("t6_pre_rdreq", 32'(chan_rdreq), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_wr", 32'(WR), 32'd0);
    check("t6_rdreq", 32'(chan_rdreq), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sel", 32'(rd_select), 32'd0);
    check("t6_data", 32'(fifodata), 32'd0);
    set_avail(0, 300);
    @(negedge rxclk);
    @(negedge rxclk);
    reset_n = 1'b1;
    verify_pkt("t6b", 16'h01F8, 16'h0000, 32'h5555_6666, 16'h03F0, 252, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
